// File: rtl/mem_pkg.sv
// Shared definitions for the MEM/WB stage: memory depth default, index width
// helper and the wait-state FSM encoding.
package mem_pkg;

  localparam int MEM_DEPTH_DEFAULT = 256;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int MEM_IDX_W = idx_width(MEM_DEPTH_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port synchronous data RAM, 32-bit words, registered read data that
// returns zero on any edge without a read.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH];

  // Word write; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[index] <= wdata;
    end
  end

  // Registered read port, cleared on reset or when no read is requested.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= mem_r[index];
    end else begin
      rdata <= 32'd0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with data memory and MEM/WB pipeline register.
// Define MEM_WAIT_STATE_EN to insert one wait state (stall) per memory access.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] result_in,
  input  logic [31:0] registro_2_in,
  input  logic [10:0] jump_dest_addr_in,
  input  logic        zero_signal_in,
  input  logic [4:0]  reg_dest_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  output logic        pc_src_out,
  output logic [10:0] branch_addr_out,
  output logic        stall_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  reg_dest_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out
);

  localparam int IDX_W = idx_width(MEM_DEPTH);

  logic [IDX_W-1:0] index_s;
  logic             stall_s;
  logic             access_s;
  logic             mem_we_s;
  logic             mem_re_s;
  logic             unused_addr_bits_s;

  assign index_s            = result_in[IDX_W+1:2];
  assign unused_addr_bits_s = ^{result_in[31:IDX_W+2], result_in[1:0]};

  assign pc_src_out      = Branch_in & zero_signal_in;
  assign branch_addr_out = jump_dest_addr_in;

`ifdef MEM_WAIT_STATE_EN
  mem_state_t state_r;

  // Wait-state sequencer: a memory op spends one edge in IDLE (stall) and
  // is performed on the following WAIT edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= (MemRead_in || MemWrite_in) ? WAIT : IDLE;
        WAIT:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Stall is raised only while a memory op waits in IDLE.
  always_comb begin
    if ((state_r == IDLE) && (MemRead_in || MemWrite_in)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  assign stall_out = stall_s;
  assign access_s  = ~stall_s;
  // Reset on an access edge abandons the write; read+write performs only the write.
  assign mem_we_s  = access_s & MemWrite_in & ~reset;
  assign mem_re_s  = access_s & MemRead_in & ~MemWrite_in;

  data_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_data_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .index (index_s),
    .wdata (registro_2_in),
    .rdata (read_data_out)
  );

  // MEM/WB register: copies on access edges, bubble on stall edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_result_out <= 32'd0;
      reg_dest_out   <= 5'd0;
      MemToReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
    end else if (access_s) begin
      alu_result_out <= result_in;
      reg_dest_out   <= reg_dest_in;
      MemToReg_out   <= MemToReg_in;
      RegWrite_out   <= RegWrite_in;
    end else begin
      alu_result_out <= 32'd0;
      reg_dest_out   <= 5'd0;
      MemToReg_out   <= 1'b0;
      RegWrite_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (either memory timing build).
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic [31:0] result_in;
  logic [31:0] registro_2_in;
  logic [10:0] jump_dest_addr_in;
  logic        zero_signal_in;
  logic [4:0]  reg_dest_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        Branch_in;
  logic        pc_src_out;
  logic [10:0] branch_addr_out;
  logic        stall_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  reg_dest_out;
  logic        MemToReg_out;
  logic        RegWrite_out;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage dut (
    .clock             (clock),
    .reset             (reset),
    .result_in         (result_in),
    .registro_2_in     (registro_2_in),
    .jump_dest_addr_in (jump_dest_addr_in),
    .zero_signal_in    (zero_signal_in),
    .reg_dest_in       (reg_dest_in),
    .MemToReg_in       (MemToReg_in),
    .RegWrite_in       (RegWrite_in),
    .MemRead_in        (MemRead_in),
    .MemWrite_in       (MemWrite_in),
    .Branch_in         (Branch_in),
    .pc_src_out        (pc_src_out),
    .branch_addr_out   (branch_addr_out),
    .stall_out         (stall_out),
    .read_data_out     (read_data_out),
    .alu_result_out    (alu_result_out),
    .reg_dest_out      (reg_dest_out),
    .MemToReg_out      (MemToReg_out),
    .RegWrite_out      (RegWrite_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    result_in = 32'd0; registro_2_in = 32'd0; jump_dest_addr_in = 11'd0;
    zero_signal_in = 1'b0; reg_dest_in = 5'd0; MemToReg_in = 1'b0;
    RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; Branch_in = 1'b0;
  endtask

  // Advance through one memory access; the wait-state build must show one
  // stall cycle with a bubble in the MEM/WB register first.
  task automatic mem_access(input string tag);
`ifdef MEM_WAIT_STATE_EN
    check_eq({tag, "_stall_hi"}, {31'd0, stall_out}, 32'd1);
    tick();
    check_eq({tag, "_stall_lo"}, {31'd0, stall_out}, 32'd0);
    check_eq({tag, "_bub_rw"}, {31'd0, RegWrite_out}, 32'd0);
    check_eq({tag, "_bub_m2r"}, {31'd0, MemToReg_out}, 32'd0);
    check_eq({tag, "_bub_alu"}, alu_result_out, 32'd0);
    check_eq({tag, "_bub_rd"}, read_data_out, 32'd0);
    tick();
`else
    check_eq({tag, "_nostall"}, {31'd0, stall_out}, 32'd0);
    tick();
`endif
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input string tag);
    clear_inputs();
    MemWrite_in = 1'b1; result_in = addr; registro_2_in = data;
    mem_access(tag);
    check_eq({tag, "_rdata0"}, read_data_out, 32'd0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] exp, input string tag);
    clear_inputs();
    MemRead_in = 1'b1; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
    result_in = addr; reg_dest_in = rd;
    mem_access(tag);
    check_eq({tag, "_rdata"}, read_data_out, exp);
    check_eq({tag, "_m2r"}, {31'd0, MemToReg_out}, 32'd1);
    check_eq({tag, "_rdest"}, {27'd0, reg_dest_out}, {27'd0, rd});
    check_eq({tag, "_alu"}, alu_result_out, addr);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_rdata", read_data_out, 32'd0);
    check_eq("rst_alu", alu_result_out, 32'd0);
    check_eq("rst_rdest", {27'd0, reg_dest_out}, 32'd0);
    check_eq("rst_m2r", {31'd0, MemToReg_out}, 32'd0);
    check_eq("rst_rw", {31'd0, RegWrite_out}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_out}, 32'd0);

    // Branch decision is combinational
    Branch_in = 1'b1; zero_signal_in = 1'b1; jump_dest_addr_in = 11'h155;
    #1;
    check_eq("br_taken", {31'd0, pc_src_out}, 32'd1);
    check_eq("br_addr", {21'd0, branch_addr_out}, 32'h155);
    zero_signal_in = 1'b0;
    #1;
    check_eq("br_nz", {31'd0, pc_src_out}, 32'd0);
    Branch_in = 1'b0; zero_signal_in = 1'b1;
    #1;
    check_eq("br_nobr", {31'd0, pc_src_out}, 32'd0);

    // Plain ALU op passes through in one cycle
    clear_inputs();
    RegWrite_in = 1'b1; result_in = 32'h7; reg_dest_in = 5'd3;
    check_eq("alu_nostall", {31'd0, stall_out}, 32'd0);
    tick();
    check_eq("alu_res", alu_result_out, 32'h7);
    check_eq("alu_rdest", {27'd0, reg_dest_out}, 32'd3);
    check_eq("alu_rw", {31'd0, RegWrite_out}, 32'd1);
    check_eq("alu_rdata", read_data_out, 32'd0);
    check_eq("alu_stall", {31'd0, stall_out}, 32'd0);

    store(32'h10, 32'hDEADBEEF, "st10");
    load(32'h10, 5'd5, 32'hDEADBEEF, "ld10");

    // Address wrap at 256 words: 0x400 aliases 0x000; low bits ignored
    store(32'h400, 32'h1234, "st400");
    load(32'h000, 5'd6, 32'h1234, "ld000");
    load(32'h013, 5'd7, 32'hDEADBEEF, "ld013");

    // Simultaneous read+write performs only the write
    clear_inputs();
    MemRead_in = 1'b1; MemWrite_in = 1'b1; result_in = 32'h20; registro_2_in = 32'h55;
    mem_access("rw20");
    check_eq("rw20_rdata", read_data_out, 32'd0);
    load(32'h20, 5'd8, 32'h55, "ld20");

    // No memory op: memory untouched, read data zero
    clear_inputs();
    result_in = 32'h20; registro_2_in = 32'h99;
    tick();
    check_eq("nop_rdata", read_data_out, 32'd0);
    load(32'h20, 5'd9, 32'h55, "ld20b");

`ifdef MEM_WAIT_STATE_EN
    // Reset while WAIT on a store must abandon the write
    store(32'h40, 32'h11111111, "st40");
    clear_inputs();
    MemWrite_in = 1'b1; result_in = 32'h40; registro_2_in = 32'h22222222;
    check_eq("wrst_stall_hi", {31'd0, stall_out}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    check_eq("wrst_stall_lo", {31'd0, stall_out}, 32'd0);
    check_eq("wrst_rw", {31'd0, RegWrite_out}, 32'd0);
    load(32'h40, 5'd10, 32'h11111111, "ld40");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 256, data-memory depth in 32-bit words; power of two.
REQ-002 clock  in  1  rising-edge clock; one clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 result_in  in  32  ALU result; the data-memory byte address for loads and stores.
REQ-005 registro_2_in  in  32  store data.
REQ-006 jump_dest_addr_in  in  11  branch target; zero_signal_in  in  1  ALU zero flag.
REQ-007 reg_dest_in  in  5  destination register.
REQ-008 MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control signals.
REQ-009 pc_src_out  out  1  branch taken; branch_addr_out  out  11  branch target.
REQ-010 stall_out  out  1  upstream holds its inputs stable while this is high.
REQ-011 read_data_out  out  32  load data (MEM/WB).
REQ-012 alu_result_out  out  32, reg_dest_out  out  5, MemToReg_out  out  1, RegWrite_out  out  1  MEM/WB copies.

Function
REQ-013 pc_src_out SHALL be combinational: Branch_in AND zero_signal_in; branch_addr_out = jump_dest_addr_in, unregistered.
REQ-014 Word index SHALL be result_in[log2(MEM_DEPTH)+1:2]; bits [1:0] are ignored; upper bits are ignored, so addresses wrap modulo MEM_DEPTH.
REQ-015 A store SHALL write registro_2_in to the indexed word on the access edge.
REQ-016 A load SHALL capture the indexed word into read_data_out on the access edge, giving 1-cycle latency aligned with the other MEM/WB outputs.
REQ-017 MemRead_in and MemWrite_in both high SHALL perform only the write and load read_data_out with 0.
REQ-018 With neither MemRead_in nor MemWrite_in, read_data_out SHALL load 0 and memory SHALL be unchanged.
REQ-019 A load from an address written on the previous edge SHALL return the new data.
REQ-020 The MEM/WB register SHALL capture alu_result_out, reg_dest_out, MemToReg_out and RegWrite_out on every access edge.
REQ-021 On a stall edge the MEM/WB register SHALL capture a bubble: RegWrite_out=0, MemToReg_out=0, other outputs 0.

Reset
REQ-022 Reset SHALL force all registered outputs to 0 and the FSM to IDLE; memory contents are not reset.
REQ-023 Reset during WAIT SHALL abandon the access: no write occurs and stall_out=0 on the next cycle.

Configuration
REQ-024 The macro MEM_WAIT_STATE_EN SHALL select the memory timing.
REQ-025 MEM_WAIT_STATE_EN defined: FSM with states IDLE and WAIT.
- IDLE with MemRead_in or MemWrite_in: stall_out=1 (combinational), bubble captured, next state WAIT.
- WAIT: stall_out=0, access performed, next state IDLE.
- Otherwise: remain in IDLE, stall_out=0.
REQ-026 MEM_WAIT_STATE_EN undefined: no FSM, stall_out tied to 0, every edge is an access edge.

Structure
REQ-027 Shared package mem_pkg SHALL hold the MEM_DEPTH default, the derived index width, and the IDLE/WAIT state encoding.
REQ-028 Sub-module data_mem SHALL implement the single-port synchronous RAM: write enable, index, write data, registered read data.

Verification
REQ-029 Store then load: MemWrite_in=1, result_in=0x10, registro_2_in=0xDEADBEEF; next cycle MemRead_in=1, result_in=0x10 -> read_data_out=0xDEADBEEF one cycle later, MemToReg_out=1.
REQ-030 Branch: Branch_in=1, zero_signal_in=1, jump_dest_addr_in=0x155 -> same-cycle pc_src_out=1, branch_addr_out=0x155; with zero_signal_in=0 -> pc_src_out=0.
REQ-031 Address wrap, MEM_DEPTH=256: store 0x1234 to 0x400, load from 0x000 -> 0x1234; load from 0x013 -> same word as 0x010.
REQ-032 Simultaneous read and write: MemRead_in=MemWrite_in=1, 0x20, data 0x55 -> read_data_out=0; a later load from 0x20 returns 0x55.
REQ-033 MEM_WAIT_STATE_EN defined, load issued -> stall_out=1 for exactly one cycle with RegWrite_out=0 bubble, then data valid one cycle later; reset asserted in WAIT on a store -> memory word unchanged.
REQ-034 Non-memory ALU op: RegWrite_in=1, result_in=0x7, reg_dest_in=3 -> next cycle alu_result_out=0x7, reg_dest_out=3, RegWrite_out=1, read_data_out=0, stall_out=0.
